// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word-addressed data RAM, loads stall upstream for WAIT extra cycles.
// Optional MEM_ALIGN_CHECK_EN: misaligned loads/stores are flagged on MisAlign and not performed.
module mem_access_stage #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  WB_EX,
  input  logic [1:0]  M_EX,
  input  logic [31:0] ALU_EX,
  input  logic [31:0] WD_EX,
  input  logic [4:0]  WN_EX,
  output logic [1:0]  WB_MEM,
  output logic [31:0] RD_MEM,
  output logic [31:0] ADDR_MEM,
  output logic [4:0]  WN_MEM,
  output logic        Stall,
  output logic        MisAlign
);
  localparam int         AW     = $clog2(DEPTH);
  localparam logic [2:0] WAIT_C = 3'(WAIT);

  typedef enum logic {IDLE, WAITING} state_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] addr;
    logic [4:0]  wn;
  } req_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] addr;
    logic [4:0]  wn;
    logic        stall;
    logic        mis;
  } rsp_t;

  logic [31:0]   mem [DEPTH];
  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  req_t          lat_q, lat_d;
  rsp_t          rsp_q, rsp_d;
  logic          we;
  logic          mis;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = (M_EX != 2'b00) && (ALU_EX[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  // A waiting load reads its latched address; EX is ignored until it completes.
  assign rd_idx  = (state_q == WAITING) ? lat_q.addr[AW+1:2] : ALU_EX[AW+1:2];
  assign rd_word = mem[rd_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    rsp_d   = '0;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        rsp_d.wb   = WB_EX;
        rsp_d.addr = ALU_EX;
        rsp_d.wn   = WN_EX;
        if (mis) begin
          rsp_d.wb  = 2'b00;
          rsp_d.mis = 1'b1;
        end else if (M_EX[0]) begin
          we = 1'b1;
        end else if (M_EX[1]) begin
          if (WAIT == 0) begin
            rsp_d.rd = rd_word;
          end else begin
            lat_d       = '{wb: WB_EX, addr: ALU_EX, wn: WN_EX};
            cnt_d       = WAIT_C;
            state_d     = WAITING;
            rsp_d       = '0;
            rsp_d.stall = 1'b1;
          end
        end
      end
      WAITING: begin
        cnt_d       = cnt_q - 3'd1;
        rsp_d.stall = 1'b1;
        if (cnt_q == 3'd1) begin
          rsp_d   = '{wb: lat_q.wb, rd: rd_word, addr: lat_q.addr, wn: lat_q.wn,
                      stall: 1'b0, mis: 1'b0};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  // RAM contents and the latched request survive reset; stores are blocked while Rst is low.
  always_ff @(posedge Clk) begin
    lat_q <= lat_d;
    if (Rst && we) mem[ALU_EX[AW+1:2]] <= WD_EX;
  end

  assign WB_MEM   = rsp_q.wb;
  assign RD_MEM   = rsp_q.rd;
  assign ADDR_MEM = rsp_q.addr;
  assign WN_MEM   = rsp_q.wn;
  assign Stall    = rsp_q.stall;
  assign MisAlign = rsp_q.mis;
endmodule
